writeback_queue: RTL and testbench

//   Write-side producer for the 32x32 register file: accepts execute/load results over a

---
 rtl/wbq_pkg.sv | 15 +
 rtl/wbq_fwd_match.sv | 37 +++
 rtl/writeback_queue.sv | 122 ++++++++++++
 tb/tb_writeback_queue.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbq_pkg.sv
// Shared types and constants for the register-file writeback queue.
package wbq_pkg;

   localparam int unsigned REG_W  = 32;
   localparam int unsigned ADDR_W = 5;

   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

   // One queued register-file write: destination register and its value.
   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [REG_W-1:0]  data;
   } wbq_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Youngest-match forwarding search for one register-file read port.
// Only instantiated when WBQ_FWD_EN is defined.
module wbq_fwd_match
   import wbq_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  wbq_entry_t                 entries [DEPTH],
   input  logic [DEPTH-1:0]           valid,
   input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
   input  logic [$clog2(DEPTH):0]     count,
   input  logic [ADDR_W-1:0]          addr,
   output logic                       hit,
   output logic [REG_W-1:0]           data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] idx;

   // Walk oldest to youngest so the last match (the youngest) wins.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = PTR_W'(rd_ptr + PTR_W'(k));
         if ((CNT_W'(k) < count) && valid[idx] &&
             (entries[idx].rd == addr) && (addr != ZERO_REG)) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback queue feeding the 32x32 register file write port,
// with optional forwarding of pending writes to two read ports.
// Forwarding compare logic is built only when WBQ_FWD_EN is defined.
module writeback_queue
   import wbq_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_rd,
   input  logic [REG_W-1:0]         in_data,
   input  logic                     drain_en,
   output logic [REG_W-1:0]         PW,
   output logic [ADDR_W-1:0]        RW,
   output logic                     LE,
   input  logic [ADDR_W-1:0]        RA,
   input  logic [ADDR_W-1:0]        RB,
   output logic                     fwd_hit_a,
   output logic                     fwd_hit_b,
   output logic [REG_W-1:0]         fwd_data_a,
   output logic [REG_W-1:0]         fwd_data_b,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wbq_entry_t        mem [DEPTH];
   wbq_entry_t        head;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic              full;
   logic              empty;
   logic              enq;
   logic              pop;

   // Occupancy decides full/empty; pointer equality is ambiguous when wrapped.
   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign in_ready = !full;

   // Writes to R0 complete the handshake but are never stored.
   assign enq = in_valid && !full && (in_rd != ZERO_REG);
   assign pop = !empty && drain_en && !Rst;

   // Register-file write port driven straight from the head entry.
   assign head = mem[rd_ptr];
   assign LE   = pop;
   assign PW   = empty ? '0 : head.data;
   assign RW   = empty ? '0 : head.rd;

   // Pointer and occupancy bookkeeping; reset discards queued entries.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
         if (pop) rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
         case ({enq, pop})
            2'b10:   count <= CNT_W'(count + CNT_W'(1));
            2'b01:   count <= CNT_W'(count - CNT_W'(1));
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are don't-care until marked occupied.
   always_ff @(posedge Clk) begin
      if (!Rst && enq) begin
         mem[wr_ptr] <= '{rd: in_rd, data: in_data};
      end
   end

`ifdef WBQ_FWD_EN
   logic [DEPTH-1:0] valid;

   // Per-slot occupancy mask consumed by the forwarding search.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         valid <= '0;
      end else begin
         if (pop) valid[rd_ptr] <= 1'b0;
         if (enq) valid[wr_ptr] <= 1'b1;
      end
   end

   wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_a (
      .entries (mem),
      .valid   (valid),
      .rd_ptr  (rd_ptr),
      .count   (count),
      .addr    (RA),
      .hit     (fwd_hit_a),
      .data    (fwd_data_a)
   );

   wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_b (
      .entries (mem),
      .valid   (valid),
      .rd_ptr  (rd_ptr),
      .count   (count),
      .addr    (RB),
      .hit     (fwd_hit_b),
      .data    (fwd_data_b)
   );
`else
   logic unused_rd_addr;

   // No forwarding: readers must stall on pending writes instead.
   assign fwd_hit_a      = 1'b0;
   assign fwd_hit_b      = 1'b0;
   assign fwd_data_a     = '0;
   assign fwd_data_b     = '0;
   assign unused_rd_addr = ^{RA, RB};
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue against a queue-based reference model.
module tb_writeback_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 3;
`ifdef WBQ_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic             Clk = 1'b0;
   logic             Rst;
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_rd;
   logic [31:0]      in_data;
   logic             drain_en;
   logic [31:0]      PW;
   logic [4:0]       RW;
   logic             LE;
   logic [4:0]       RA;
   logic [4:0]       RB;
   logic             fwd_hit_a;
   logic             fwd_hit_b;
   logic [31:0]      fwd_data_a;
   logic [31:0]      fwd_data_b;
   logic [CNT_W-1:0] count;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] rf [32];
   int          n_checks = 0;
   int          n_fail   = 0;

   writeback_queue #(.DEPTH(DEPTH)) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rd      (in_rd),
      .in_data    (in_data),
      .drain_en   (drain_en),
      .PW         (PW),
      .RW         (RW),
      .LE         (LE),
      .RA         (RA),
      .RB         (RB),
      .fwd_hit_a  (fwd_hit_a),
      .fwd_hit_b  (fwd_hit_b),
      .fwd_data_a (fwd_data_a),
      .fwd_data_b (fwd_data_b),
      .count      (count)
   );

   always #5 Clk = ~Clk;

   // Youngest queued value for an address, as readers should see it.
   function automatic void model_fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
      h = 1'b0;
      d = 32'h0;
      if (FWD && a != 5'd0) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rd == a) begin
               h = 1'b1;
               d = mq[i].data;
               break;
            end
         end
      end
   endfunction

   // One clock: register file captures the write port, model applies the rules.
   task automatic tick();
      bit          push;
      bit          pop;
      logic        le_s;
      logic [4:0]  rw_s;
      logic [31:0] pw_s;
      ent_t        e;
      #1;
      push = !Rst && in_valid && (mq.size() != DEPTH) && (in_rd != 5'd0);
      pop  = !Rst && drain_en && (mq.size() != 0);
      le_s = LE;
      rw_s = RW;
      pw_s = PW;
      e.rd   = in_rd;
      e.data = in_data;
      @(posedge Clk);
      if (le_s === 1'b1 && rw_s != 5'd0) rf[rw_s] = pw_s;
      if (Rst) mq.delete();
      else begin
         if (pop)  void'(mq.pop_front());
         if (push) mq.push_back(e);
      end
      @(negedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Rst = 1'b1; in_valid = 1'b0; drain_en = 1'b0; RA = 5'd0; RB = 5'd0;
      in_rd = 5'd0; in_data = 32'h0;
      tick(); tick();
      Rst = 1'b0; #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0h want 1", in_ready); end
      n_checks++; if (LE !== 1'b0) begin n_fail++; $display("FAIL reset_le: got %0h want 0", LE); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      n_checks++; if (fwd_hit_a !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_hit_a: got %0h want 0", fwd_hit_a); end
      n_checks++; if (PW !== 32'h0 || RW !== 5'd0) begin n_fail++; $display("FAIL reset_pw_rw: got %0h/%0h want 0/0", PW, RW); end
   endtask

   task automatic test_single();
      drain_en = 1'b1; in_valid = 1'b1; in_rd = 5'd5; in_data = 32'hDEADBEEF;
      tick();
      in_valid = 1'b0; #1;
      n_checks++; if (LE !== 1'b1) begin n_fail++; $display("FAIL single_le: got %0h want 1", LE); end
      n_checks++; if (RW !== 5'd5) begin n_fail++; $display("FAIL single_rw: got %0d want 5", RW); end
      n_checks++; if (PW !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_pw: got %0h want deadbeef", PW); end
      tick();
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count: got %0d want 0", count); end
      n_checks++; if (rf[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rf5: got %0h want deadbeef", rf[5]); end
   endtask

   task automatic test_full_stall();
      logic [4:0] exp_rw [5];
      int         accepted;
      bit         acc;
      exp_rw = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9};
      drain_en = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_rd = 5'(i); in_data = 32'h100 + 32'(i);
         tick();
      end
      in_valid = 1'b1; in_rd = 5'd9; in_data = 32'h900; #1;
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
      for (int c = 0; c < 3; c++) begin
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %0h want 0", c, in_ready); end
         n_checks++; if (LE !== 1'b0) begin n_fail++; $display("FAIL stall_le[%0d]: got %0h want 0", c, LE); end
         tick();
      end
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL stall_count: got %0d want 4", count); end
      drain_en = 1'b1; accepted = 0; #1;
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (LE !== 1'b1 || RW !== exp_rw[i]) begin n_fail++; $display("FAIL drain_seq[%0d]: got le=%0h rw=%0d want le=1 rw=%0d", i, LE, RW, exp_rw[i]); end
         acc = in_valid && in_ready;
         tick();
         if (acc) begin accepted++; in_valid = 1'b0; #1; end
      end
      n_checks++; if (accepted != 1) begin n_fail++; $display("FAIL fifth_accepted: got %0d want 1", accepted); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", count); end
      n_checks++; if (rf[9] !== 32'h900 || rf[4] !== 32'h104) begin n_fail++; $display("FAIL drain_rf: got r9=%0h r4=%0h want 900/104", rf[9], rf[4]); end
   endtask

   task automatic test_r0();
      drain_en = 1'b1; in_valid = 1'b1; in_rd = 5'd0; in_data = 32'h1; #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready: got %0h want 1", in_ready); end
      tick();
      in_valid = 1'b0; #1;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL r0_count: got %0d want 0", count); end
      n_checks++; if (LE !== 1'b0) begin n_fail++; $display("FAIL r0_le: got %0h want 0", LE); end
   endtask

   task automatic test_fwd();
      drain_en = 1'b0;
      in_valid = 1'b1; in_rd = 5'd7; in_data = 32'hA; tick();
      in_rd = 5'd7; in_data = 32'hB; tick();
      in_valid = 1'b0; RA = 5'd7; RB = 5'd8; #1;
      n_checks++; if (fwd_hit_a !== FWD || fwd_data_a !== (FWD ? 32'hB : 32'h0)) begin n_fail++; $display("FAIL fwd_youngest: got %0h/%0h want %0h/%0h", fwd_hit_a, fwd_data_a, FWD, FWD ? 32'hB : 32'h0); end
      n_checks++; if (fwd_hit_b !== 1'b0 || fwd_data_b !== 32'h0) begin n_fail++; $display("FAIL fwd_miss_b: got %0h/%0h want 0/0", fwd_hit_b, fwd_data_b); end
      in_valid = 1'b1; in_rd = 5'd0; in_data = 32'h77; RA = 5'd0; #1;
      n_checks++; if (fwd_hit_a !== 1'b0 || fwd_data_a !== 32'h0) begin n_fail++; $display("FAIL fwd_r0: got %0h/%0h want 0/0", fwd_hit_a, fwd_data_a); end
      tick();
      in_rd = 5'd8; in_data = 32'hC; #1;
      n_checks++; if (fwd_hit_b !== 1'b0) begin n_fail++; $display("FAIL fwd_same_cycle_push: got %0h want 0", fwd_hit_b); end
      tick();
      in_valid = 1'b0; #1;
      n_checks++; if (fwd_hit_b !== FWD || fwd_data_b !== (FWD ? 32'hC : 32'h0)) begin n_fail++; $display("FAIL fwd_after_push: got %0h/%0h", fwd_hit_b, fwd_data_b); end
      drain_en = 1'b1; RA = 5'd7; tick();
      n_checks++; if (RW !== 5'd7 || fwd_hit_a !== FWD || fwd_data_a !== (FWD ? 32'hB : 32'h0)) begin n_fail++; $display("FAIL fwd_head_popping: got rw=%0d %0h/%0h", RW, fwd_hit_a, fwd_data_a); end
      tick();
      n_checks++; if (fwd_hit_a !== 1'b0 || fwd_hit_b !== FWD) begin n_fail++; $display("FAIL fwd_after_drain: got a=%0h b=%0h want a=0 b=%0h", fwd_hit_a, fwd_hit_b, FWD); end
      tick();
      n_checks++; if (count !== 3'd0 || rf[7] !== 32'hB) begin n_fail++; $display("FAIL fwd_drain_order: got count=%0d r7=%0h want 0/b", count, rf[7]); end
      RA = 5'd0; RB = 5'd0;
   endtask

   task automatic test_wrap_reset();
      logic [31:0] snap [32];
      int          diffs;
      drain_en = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_rd = 5'($urandom_range(1, 31)); in_data = $urandom; tick();
      end
      drain_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_rd = 5'($urandom_range(1, 31)); in_data = $urandom; #1;
         n_checks++; if (count !== 3'd2 || LE !== 1'b1) begin n_fail++; $display("FAIL wrap_count[%0d]: got cnt=%0d le=%0h want 2/1", i, count, LE); end
         n_checks++; if (RW !== mq[0].rd || PW !== mq[0].data) begin n_fail++; $display("FAIL wrap_order[%0d]: got %0d/%0h want %0d/%0h", i, RW, PW, mq[0].rd, mq[0].data); end
         tick();
      end
      drain_en = 1'b0; in_rd = 5'd3; in_data = 32'h333; tick();
      in_valid = 1'b0; #1;
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL pre_reset_count: got %0d want 3", count); end
      snap = rf;
      Rst = 1'b1; drain_en = 1'b1; #1;
      n_checks++; if (LE !== 1'b0) begin n_fail++; $display("FAIL reset_blocks_le: got %0h want 0", LE); end
      tick();
      Rst = 1'b0; #1;
      n_checks++; if (count !== 3'd0 || LE !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got cnt=%0d le=%0h want 0/0", count, LE); end
      diffs = 0;
      for (int r = 0; r < 32; r++) if (rf[r] !== snap[r]) diffs++;
      n_checks++; if (diffs != 0) begin n_fail++; $display("FAIL reset_rf_write: got %0d changed regs want 0", diffs); end
   endtask

   task automatic test_random();
      logic        eh;
      logic [31:0] ed;
      for (int n = 0; n < 300; n++) begin
         Rst      = ($urandom_range(0, 59) == 0);
         in_valid = $urandom_range(0, 1) == 1;
         in_rd    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
         in_data  = $urandom;
         drain_en = $urandom_range(0, 2) != 0;
         RA       = 5'($urandom_range(0, 7));
         RB       = 5'($urandom_range(0, 7));
         #1;
         n_checks++; if (count !== CNT_W'(mq.size())) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, count, mq.size()); end
         n_checks++; if (in_ready !== (mq.size() != DEPTH)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %0h", n, in_ready); end
         n_checks++; if (LE !== (!Rst && drain_en && mq.size() != 0)) begin n_fail++; $display("FAIL rnd_le[%0d]: got %0h", n, LE); end
         n_checks++;
         if (mq.size() == 0 ? (PW !== 32'h0 || RW !== 5'd0) : (PW !== mq[0].data || RW !== mq[0].rd)) begin
            n_fail++; $display("FAIL rnd_head[%0d]: got %0d/%0h", n, RW, PW);
         end
         model_fwd(RA, eh, ed);
         n_checks++; if (fwd_hit_a !== eh || fwd_data_a !== ed) begin n_fail++; $display("FAIL rnd_fwd_a[%0d]: got %0h/%0h want %0h/%0h", n, fwd_hit_a, fwd_data_a, eh, ed); end
         model_fwd(RB, eh, ed);
         n_checks++; if (fwd_hit_b !== eh || fwd_data_b !== ed) begin n_fail++; $display("FAIL rnd_fwd_b[%0d]: got %0h/%0h want %0h/%0h", n, fwd_hit_b, fwd_data_b, eh, ed); end
         tick();
      end
      Rst = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      for (int r = 0; r < 32; r++) rf[r] = 32'h0;
      @(negedge Clk);
      test_reset();
      test_single();
      test_full_stall();
      test_r0();
      test_fwd();
      test_wrap_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
